// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pkg
// Purpose  : Shared constants and state encoding for the instruction-fetch
//            stage (NOP encoding, default widths, fetch FSM states).
// Revision : 1.0  initial release
// ============================================================================
package if_stage_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int DATA_W_DEF = 32;

  // addi x0, x0, 0
  localparam logic [31:0] CORE_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

endpackage
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_skid_buf
// Purpose  : One-entry {pc, instruction} holding buffer. Catches a fetch
//            response that arrives while the IF/ID register is stalled.
//            Priority: clear > push > pop.
// Revision : 1.0  initial release
// ============================================================================
module if_skid_buf
  import if_stage_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [DATA_W-1:0] push_instr,
  output logic              full,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] instr
);

  logic              full_q,  full_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;

  // Next-entry selection: a clear wins over a simultaneous push.
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      pc_d    = push_pc;
      instr_d = push_instr;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= DATA_W'(CORE_NOP);
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full  = full_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage. Owns the PC, issues at most one
//            outstanding instruction-bus request, and drives the IF/ID
//            pipeline register. Honours stall, flush and branch redirect.
//            Optional build macro IF_MISALIGN_CHECK_EN adds if2id_misalign
//            and halts fetch on a misaligned redirect target.
// Revision : 1.0  initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_stall,
  input  logic              if_flush,
  input  logic              branch_take,
  input  logic [PC_W-1:0]   branch_pc,
  output logic              ibus_req,
  output logic [PC_W-1:0]   ibus_addr,
  input  logic              ibus_ready,
  input  logic              ibus_rvalid,
  input  logic [DATA_W-1:0] ibus_rdata,
  output logic              if2id_valid,
  output logic [PC_W-1:0]   if2id_pc,
  output logic [DATA_W-1:0] if2id_instruction
`ifdef IF_MISALIGN_CHECK_EN
  ,output logic             if2id_misalign
`endif
);

  if_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic              valid_q, valid_d;
  logic [PC_W-1:0]   opc_q, opc_d;
  logic [DATA_W-1:0] oinstr_q, oinstr_d;

  logic              skid_push, skid_pop, skid_clear, skid_full;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_instr;

  logic              halt;
  logic [PC_W-1:0]   branch_tgt;
  logic              deliver;
  logic              out_free;

`ifdef IF_MISALIGN_CHECK_EN
  logic halt_q, halt_d, mis_q, mis_d;
  logic misalign_target;
  assign misalign_target = branch_take && (branch_pc[1:0] != 2'b00);
  assign branch_tgt      = branch_pc;
  assign halt            = halt_q;
  assign if2id_misalign  = mis_q;
`else
  // Low target bits carry no meaning without the misalign check.
  logic unused_bpc_lo;
  assign unused_bpc_lo = ^branch_pc[1:0];
  assign branch_tgt    = {branch_pc[PC_W-1:2], 2'b00};
  assign halt          = 1'b0;
`endif

  // A response is only meaningful while a request is outstanding; a redirect
  // in the same cycle makes it stale.
  assign deliver  = (state_q == IF_WAIT) && ibus_rvalid && !drop_q && !branch_take;
  assign out_free = !if_stall || !valid_q;

  if_skid_buf #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push),
    .pop        (skid_pop),
    .clear      (skid_clear),
    .push_pc    (req_pc_q),
    .push_instr (ibus_rdata),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // IF/ID register / skid steering, then fetch FSM next-state and bus request.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    opc_d      = opc_q;
    oinstr_d   = oinstr_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
    ibus_req   = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    halt_d     = halt_q;
    mis_d      = mis_q;
`endif

    if (branch_take) begin
      skid_clear = 1'b1;
      valid_d    = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      mis_d  = 1'b0;
      halt_d = misalign_target;
      if (misalign_target) begin
        valid_d  = 1'b1;
        opc_d    = branch_pc;
        oinstr_d = DATA_W'(CORE_NOP);
        mis_d    = 1'b1;
      end
`endif
    end else if (if_flush) begin
      skid_clear = 1'b1;
      valid_d    = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      mis_d = 1'b0;
`endif
      if (deliver) begin
        valid_d  = 1'b1;
        opc_d    = req_pc_q;
        oinstr_d = ibus_rdata;
      end
    end else if (out_free) begin
`ifdef IF_MISALIGN_CHECK_EN
      mis_d = 1'b0;
`endif
      if (skid_full) begin
        skid_pop = 1'b1;
        valid_d  = 1'b1;
        opc_d    = skid_pc;
        oinstr_d = skid_instr;
      end else if (deliver) begin
        valid_d  = 1'b1;
        opc_d    = req_pc_q;
        oinstr_d = ibus_rdata;
      end else if (!if_stall) begin
        valid_d = 1'b0;
      end
    end else if (deliver) begin
      skid_push = 1'b1;
    end

    case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        ibus_req = !halt && !skid_full;
        if (ibus_req && ibus_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_W'(4);
          state_d  = IF_WAIT;
          if (branch_take) drop_d = 1'b1;
        end
      end
      IF_WAIT: begin
        if (ibus_rvalid) begin
          drop_d  = 1'b0;
          state_d = skid_push ? IF_HOLD : IF_REQ;
        end else if (branch_take) begin
          drop_d = 1'b1;
        end
      end
      IF_HOLD: begin
        if (!if_stall || branch_take || if_flush) state_d = IF_REQ;
      end
      default: state_d = IF_IDLE;
    endcase

    if (branch_take) pc_d = branch_tgt;
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IF_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      opc_q    <= RESET_PC;
      oinstr_q <= DATA_W'(CORE_NOP);
`ifdef IF_MISALIGN_CHECK_EN
      halt_q   <= 1'b0;
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      opc_q    <= opc_d;
      oinstr_q <= oinstr_d;
`ifdef IF_MISALIGN_CHECK_EN
      halt_q   <= halt_d;
      mis_q    <= mis_d;
`endif
    end
  end

  assign ibus_addr         = {pc_q[PC_W-1:2], 2'b00};
  assign if2id_valid       = valid_q;
  assign if2id_pc          = opc_q;
  assign if2id_instruction = oinstr_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: per-cycle vector table,
//            response scoreboard, and hand sequences for async reset and the
//            optional misaligned-redirect feature.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_stall, if_flush, branch_take;
  logic [31:0] branch_pc;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready, ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        if2id_valid;
  logic [31:0] if2id_pc, if2id_instruction;
`ifdef IF_MISALIGN_CHECK_EN
  logic        if2id_misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic bus_en;
  logic mon_en;
  int   resp_delay;

  typedef struct {
    logic        st, fl, br;
    logic [31:0] bpc;
    int          dly;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[28];

  if_stage #(
    .PC_W     (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_stall          (if_stall),
    .if_flush          (if_flush),
    .branch_take       (branch_take),
    .branch_pc         (branch_pc),
    .ibus_req          (ibus_req),
    .ibus_addr         (ibus_addr),
    .ibus_ready        (ibus_ready),
    .ibus_rvalid       (ibus_rvalid),
    .ibus_rdata        (ibus_rdata),
    .if2id_valid       (if2id_valid),
    .if2id_pc          (if2id_pc),
    .if2id_instruction (if2id_instruction)
`ifdef IF_MISALIGN_CHECK_EN
    ,.if2id_misalign   (if2id_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h00A0_0093 ^ {a[23:0], 8'h00};
  endfunction

  function automatic vec_t mk(input logic st, input logic fl, input logic br,
                              input logic [31:0] bpc, input int dly,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] epc);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.bpc = bpc; v.dly = dly;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: acceptance sampled mid-cycle, response driven after edge.
  initial begin
    logic        acc, pend;
    logic [31:0] acc_addr, paddr;
    int          cnt;
    pend = 1'b0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk);
      acc      = ibus_req && ibus_ready;
      acc_addr = ibus_addr;
      @(posedge clk);
      #3;
      if (!bus_en) begin
        pend = 1'b0;
      end else begin
        ibus_rvalid = 1'b0;
        if (acc) begin
          pend  = 1'b1;
          paddr = acc_addr;
          cnt   = resp_delay;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = mem(paddr);
            pend        = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard: expected words queued on live responses, checked when the
  // presented instruction leaves IF/ID (consumed, flushed or redirected).
  initial begin
    logic        outstanding, pend_kill;
    logic [31:0] pend_addr;
    exp_t        e;
    outstanding = 1'b0; pend_kill = 1'b0; pend_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        sbq.delete();
        outstanding = 1'b0;
        pend_kill   = 1'b0;
      end else begin
        if (if2id_valid && (!if_stall || if_flush || branch_take)) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got pc %h with nothing expected", if2id_pc);
          end else begin
            e = sbq.pop_front();
            chk("sb_pc", if2id_pc, e.pc);
            chk("sb_instr", if2id_instruction, e.instr);
          end
        end
        if (ibus_rvalid && outstanding) begin
          if (!pend_kill && !branch_take) sbq.push_back('{pend_addr, mem(pend_addr)});
          outstanding = 1'b0;
        end else if (outstanding && branch_take) begin
          pend_kill = 1'b1;
        end
        if (ibus_req && ibus_ready) begin
          outstanding = 1'b1;
          pend_kill   = branch_take;
          pend_addr   = ibus_addr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //            st fl br bpc           dly req addr          v  pc
    tbl[0]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[5]  = mk(1, 0, 0, 32'h0,        1, 1, 32'h8,        1, 32'h4);
    tbl[6]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4);
    tbl[7]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4);
    tbl[8]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4);
    tbl[9]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4);
    tbl[10] = mk(0, 0, 0, 32'h0,        1, 1, 32'hC,        1, 32'h8);
    tbl[11] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[12] = mk(0, 0, 0, 32'h0,        1, 1, 32'h10,       1, 32'hC);
    tbl[13] = mk(0, 0, 1, 32'h100,      2, 0, 32'h0,        0, 32'h0);
    tbl[14] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[15] = mk(0, 0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0);
    tbl[16] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[17] = mk(1, 0, 0, 32'h0,        1, 1, 32'h104,      1, 32'h100);
    tbl[18] = mk(1, 0, 1, 32'h200,      1, 0, 32'h0,        1, 32'h100);
    tbl[19] = mk(0, 0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h0);
    tbl[20] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[21] = mk(1, 1, 0, 32'h0,        1, 1, 32'h204,      1, 32'h200);
    tbl[22] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[23] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h208,     1, 32'h204);
    tbl[24] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[25] = mk(0, 0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0);
    tbl[26] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[27] = mk(1, 0, 0, 32'h0,        1, 1, 32'h0,        1, 32'hFFFF_FFFC);

    rst_n = 1'b0; if_stall = 1'b0; if_flush = 1'b0; branch_take = 1'b0;
    branch_pc = '0; ibus_ready = 1'b1; ibus_rvalid = 1'b0; ibus_rdata = '0;
    bus_en = 1'b1; mon_en = 1'b1; resp_delay = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", ibus_req, 1'b0);
    chk("rst_valid", if2id_valid, 1'b0);
    chk("rst_pc", if2id_pc, 32'h0);
    chk("rst_instr", if2id_instruction, NOP);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      if_stall    = tbl[i].st;
      if_flush    = tbl[i].fl;
      branch_take = tbl[i].br;
      branch_pc   = tbl[i].bpc;
      resp_delay  = tbl[i].dly;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), ibus_req, tbl[i].ereq);
      if (tbl[i].ereq) chk($sformatf("v%0d_addr", i), ibus_addr, tbl[i].eaddr);
      chk($sformatf("v%0d_valid", i), if2id_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), if2id_pc, tbl[i].epc);
        chk($sformatf("v%0d_instr", i), if2id_instruction, mem(tbl[i].epc));
      end
    end

    // Async reset in the middle of an outstanding fetch.
    @(posedge clk);
    #1;
    if_stall = 1'b1; branch_take = 1'b0; resp_delay = 4;
    @(negedge clk);
    chk("pre_rst_valid", if2id_valid, 1'b1);
    #2;
    rst_n = 1'b0; bus_en = 1'b0; if_stall = 1'b0; ibus_ready = 1'b0;
    #1;
    chk("arst_req", ibus_req, 1'b0);
    chk("arst_valid", if2id_valid, 1'b0);
    chk("arst_pc", if2id_pc, 32'h0);
    chk("arst_instr", if2id_instruction, NOP);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1; ibus_rvalid = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("r0_req", ibus_req, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("r1_req", ibus_req, 1'b1);
    chk("r1_addr", ibus_addr, 32'h0);
    @(posedge clk);
    #1;
    ibus_rvalid = 1'b0; ibus_ready = 1'b1; resp_delay = 1; bus_en = 1'b1;
    @(negedge clk);
    chk("r2_stale_valid", if2id_valid, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("r4_valid", if2id_valid, 1'b1);
    chk("r4_pc", if2id_pc, 32'h0);
    chk("r4_instr", if2id_instruction, mem(32'h0));
    @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);

`ifdef IF_MISALIGN_CHECK_EN
    mon_en = 1'b0;
    branch_take = 1'b1; branch_pc = 32'h102;
    @(posedge clk);
    #1;
    branch_take = 1'b0;
    @(negedge clk);
    chk("mis_valid", if2id_valid, 1'b1);
    chk("mis_flag", if2id_misalign, 1'b1);
    chk("mis_instr", if2id_instruction, NOP);
    chk("mis_req", ibus_req, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("mis_halt_req", ibus_req, 1'b0);
    @(posedge clk);
    #1;
    branch_take = 1'b1; branch_pc = 32'h200;
    @(posedge clk);
    #1;
    branch_take = 1'b0;
    @(negedge clk);
    chk("mis_resume_req", ibus_req, 1'b1);
    chk("mis_resume_addr", ibus_addr, 32'h200);
    chk("mis_resume_flag", if2id_misalign, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
